// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the MEM stage.
//
// Accepts one load/store at a time over a valid/ready channel, waits
// WAIT_CYCLES, then performs the access. It answers with a single-cycle
// resp_valid pulse. Stores merge byte lanes into the addressed word, and
// the merged word is returned on resp_rdata.
//
// Parameters
//   DEPTH_LOG2  log2 of the RAM word count
//   WAIT_CYCLES wait states between accept and access (0..15)
//   BASE_ADDR   byte address of word 0
// Ports
//   clk, reset (synchronous, active-low)
//   req_valid/req_ready  request handshake
//   req_write, req_addr, req_be, req_wdata, req_pc  request fields
//   resp_valid  one-cycle completion pulse
//   resp_rdata  loaded or merged word; held until the next response
//   resp_err    out-of-range address
// Optional feature
//   DM_TRACE_EN  when defined, prints one line per committed store.
module dm_responder #(
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic        write_reg;
   logic [31:0] addr_reg;
   logic [3:0]  be_reg;
   logic [31:0] wdata_reg;
   logic [31:0] pc_reg;

   logic [31:0] mem [DEPTH];

   logic                  handshake;
   logic                  access_now;
   logic                  use_req;
   logic                  acc_write;
   logic [31:0]           acc_addr;
   logic [3:0]            acc_be;
   logic [31:0]           acc_wdata;
   logic [31:0]           acc_pc;
   logic [31:0]           acc_word;
   logic [31:0]           acc_off;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic                  in_range;
   logic [31:0]           old_word;
   logic [31:0]           merged_word;
   logic                  do_write;
   logic                  unused_bits;

   assign handshake = req_valid & req_ready;

   // With no wait states the access happens on the accepting edge itself,
   // straight from the request inputs; otherwise the latched copy is used.
   assign access_now = (handshake && (WAIT_CYCLES == 0)) ||
                       ((state_reg == S_WAIT) && (cnt_reg <= 4'd1));
   assign use_req    = (state_reg == S_IDLE);

   assign acc_write = use_req ? req_write : write_reg;
   assign acc_addr  = use_req ? req_addr  : addr_reg;
   assign acc_be    = use_req ? req_be    : be_reg;
   assign acc_wdata = use_req ? req_wdata : wdata_reg;
   assign acc_pc    = use_req ? req_pc    : pc_reg;

   assign acc_word = {acc_addr[31:2], 2'b00};
   assign acc_off  = acc_word - BASE_ADDR;
   assign acc_idx  = acc_off[DEPTH_LOG2+1:2];
   // The underflow check matters: a wrapped offset could otherwise look small.
   assign in_range = (acc_word >= BASE_ADDR) &&
                     ({2'b00, acc_off[31:2]} < 32'(DEPTH));

   assign old_word = mem[acc_idx];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign merged_word[8*gi +: 8] = acc_be[gi] ? acc_wdata[8*gi +: 8]
                                                    : old_word[8*gi +: 8];
      end
   endgenerate

   // A store with no byte enables would rewrite the same word, so it is skipped.
   assign do_write = access_now && in_range && acc_write && (|acc_be);

   assign unused_bits = ^{acc_addr[1:0], acc_off[1:0], acc_pc};

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_write) begin
         mem[acc_idx] <= merged_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         write_reg  <= 1'b0;
         addr_reg   <= '0;
         be_reg     <= '0;
         wdata_reg  <= '0;
         pc_reg     <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (handshake) begin
                  write_reg <= req_write;
                  addr_reg  <= req_addr;
                  be_reg    <= req_be;
                  wdata_reg <= req_wdata;
                  pc_reg    <= req_pc;
                  cnt_reg   <= 4'(WAIT_CYCLES);
                  req_ready <= 1'b0;
                  state_reg <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               req_ready <= 1'b0;
               if (cnt_reg <= 4'd1) begin
                  cnt_reg   <= '0;
                  state_reg <= S_RESP;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            S_RESP: begin
               req_ready <= 1'b1;
               state_reg <= S_IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state_reg <= S_IDLE;
            end
         endcase
         if (access_now) begin
            resp_valid <= 1'b1;
            resp_err   <= !in_range;
            resp_rdata <= !in_range ? 32'h0 : (acc_write ? merged_word : old_word);
         end
      end
   end

`ifdef DM_TRACE_EN
   always @(posedge clk) begin
      if (reset && do_write)
         $display("%d@%h: *%h <= %h", $time, acc_pc, acc_word, merged_word);
   end
`else
`endif

endmodule
